// File: rtl/mod_counter.sv
// mod_counter: parametrised up/down counter with clamp-on-load, wrap/saturate limits,
// an enable-gated prescaler and a registered one-cycle limit event pulse.
module mod_counter #(
   parameter int WIDTH     = 4,
   parameter int MAX_VALUE = 2**WIDTH-1,
   parameter bit SATURATE  = 1'b0,
   parameter int PRESCALE  = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             up_down,
   output logic [WIDTH-1:0] counter_out,
   output logic             at_limit,
   output logic             wrap
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX_VALUE);
   localparam logic [PW-1:0]    PLAST = PW'(PRESCALE-1);
   logic [PW-1:0]    pre, pre_nxt;
   logic [WIDTH-1:0] cnt_nxt, ld_val;
   logic             step, wrap_nxt;
   assign at_limit = up_down ? counter_out == MAXV : counter_out == '0;
   assign step     = enable && pre == PLAST;
   assign ld_val   = load_value > MAXV ? MAXV : load_value;
   // limits are compared explicitly so a short modulus never relies on natural overflow
   always_comb begin
      pre_nxt  = pre;
      cnt_nxt  = counter_out;
      wrap_nxt = 1'b0;
      if (clear) begin
         pre_nxt = '0;
         cnt_nxt = '0;
      end else if (load) begin
         pre_nxt = '0;
         cnt_nxt = ld_val;
      end else if (enable) begin
         pre_nxt = step ? '0 : pre + 1'b1;
         if (step) begin
            wrap_nxt = at_limit;
            cnt_nxt  = at_limit ? (SATURATE ? counter_out : (up_down ? '0 : MAXV))
                                : (up_down ? counter_out + 1'b1 : counter_out - 1'b1);
         end
      end
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         counter_out <= '0;
         pre         <= '0;
         wrap        <= 1'b0;
      end else begin
         counter_out <= cnt_nxt;
         pre         <= pre_nxt;
         wrap        <= wrap_nxt;
      end
   end
endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised up/down counter, the successor of the fixed 4-bit enable counter. It adds configurable width and modulus, direction control, synchronous clear and load, wrap or saturate mode, a clock-enable prescaler, and a registered wrap/limit event pulse. It is a general-purpose timing and counting primitive, instantiated directly by control logic and exercised stand-alone by its own testbench.

## Interface
- WIDTH, 4: counter width in bits, ≥1.
- MAX_VALUE, 2**WIDTH-1: highest count value; count range is 0..MAX_VALUE. Must be ≤ 2**WIDTH-1.
- SATURATE, 0: 0 = wrap at limits; 1 = hold at limits.
- PRESCALE, 1: the counter steps once per PRESCALE enabled cycles. Must be ≥1.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Assertion (0) resets all state immediately. Deassertion is taken synchronously to clock by the integrator.
- enable  in  1  count enable; it also gates the prescaler.
- clear  in  1  synchronous clear to 0.
- load  in  1  synchronous load of load_value.
- load_value  in  WIDTH  value to load.
- up_down  in  1  1 = count up, 0 = count down.
- counter_out  out  WIDTH  current count (registered).
- at_limit  out  1  combinational flag: counter_out==MAX_VALUE when up_down=1, counter_out==0 when up_down=0.
- wrap  out  1  registered one-cycle event pulse.

## Operation
- Reset values: counter_out=0, wrap=0, internal prescaler count=0.
- Per-edge priority: clear > load > step > hold.
- clear=1: counter_out←0, prescaler←0, wrap←0.
- load=1 (and clear=0): counter_out←min(load_value, MAX_VALUE), prescaler←0, wrap←0. An out-of-range load clamps silently.
- Prescaler: an internal counter of width max(1,$clog2(PRESCALE)).
  - It advances only when enable=1 and there is no clear or load.
  - step = enable && (prescaler==PRESCALE-1). On step, prescaler←0.
  - With PRESCALE=1, step = enable.
  - With enable=0, the prescaler holds its value and is not reset.
- Step, up (up_down=1):
  - counter_out<MAX_VALUE: counter_out+1.
  - counter_out==MAX_VALUE: →0 if SATURATE=0, hold if SATURATE=1.
- Step, down (up_down=0):
  - counter_out>0: counter_out−1.
  - counter_out==0: →MAX_VALUE if SATURATE=0, hold if SATURATE=1.
- wrap←1 for exactly one cycle after any step taken while at_limit=1, whether the counter wrapped or held in saturate mode. Otherwise wrap←0.
- up_down may change on any cycle. It is sampled on the same edge as step, and at_limit follows it combinationally.
- Arithmetic is in WIDTH bits. Because the limits are compared explicitly, results never depend on natural 2**WIDTH overflow when MAX_VALUE<2**WIDTH-1.

## Timing
- Step latency: counter_out updates on the rising edge where step is true. The new value is visible in the following cycle.
- Load and clear latency: 1 edge. No pipeline.
- wrap is asserted during the same cycle in which counter_out shows the post-wrap value (0 or MAX_VALUE).
- load and clear arriving together: clear wins.
- load and a step on the same edge: load wins and the step is discarded.
- Asynchronous reset mid-count: counter_out, wrap and the prescaler go to 0 without waiting for a clock edge. Counting resumes on the first enabled edge after release.
- Consecutive wraps are possible with PRESCALE=1 and MAX_VALUE=0, giving wrap=1 continuously while enable=1.

## Test plan
- Defaults, reset low for 10 cycles, then enable=1, up_down=1 for 10 cycles → counter_out 1,2,…,10. After enable drops, the counter holds 10 and wrap stays 0.
- Defaults, load_value=14, load, then 3 up steps → counter_out 15, 0, 1. wrap=1 only in the cycle showing 0, and at_limit=1 while at 15.
- MAX_VALUE=9, SATURATE=0: load 0, then count down → counter_out 9 with wrap=1. load_value=12 → counter_out 9 (clamped).
- MAX_VALUE=9, SATURATE=1: count up from 8 for 4 steps → 9, 9, 9, 9. wrap=1 on each of the last 3 held steps. Then count down → 8.
- PRESCALE=3: enable=1 for 9 cycles → counter_out increments every 3rd cycle, reaching 3. Dropping enable for 2 cycles mid-period does not lose prescaler progress. A clear restarts the prescaler phase.
- Reset pulled low asynchronously between edges while counter_out=7 and wrap=1 → both go to 0 immediately. Simultaneous clear+load with load_value=5 → counter_out=0.
